// File: rtl/imm_gen_pipe.sv
// Immediate decoder feeding a small output FIFO; one-cycle accept-to-visible latency.
// Optional IW (move-wide) decode is enabled by defining IMM_GEN_IW_EN.
module imm_gen_pipe #(
    parameter int DATA_W   = 64,
    parameter int DEPTH    = 2,
    parameter int SHIFT_BR = 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     flush,
    input  logic                     in_valid,
    input  logic [31:0]              in_instr,
    output logic                     in_ready,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [DATA_W-1:0]        out_imm,
    output logic [2:0]               out_fmt,
    output logic                     out_err,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [2:0] {
        FMT_NONE = 3'd0,
        FMT_B    = 3'd1,
        FMT_CB   = 3'd2,
        FMT_D    = 3'd3,
        FMT_I    = 3'd4,
        FMT_IW   = 3'd5
    } fmt_e;

    fmt_e        dec_fmt;
    logic [63:0] dec_imm;
    logic        dec_err;

    logic [DATA_W-1:0] imm_mem_q [DEPTH];
    logic [2:0]        fmt_mem_q [DEPTH];
    logic              err_mem_q [DEPTH];

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             push, pop;

    // First-match decode; everything is formed at 64 bits and truncated on store.
    always_comb begin
        dec_fmt = FMT_NONE;
        dec_imm = '0;
        dec_err = 1'b0;
        if (in_instr[31:26] == 6'b000101) begin
            dec_fmt = FMT_B;
            dec_imm = (SHIFT_BR != 0) ? {{36{in_instr[25]}}, in_instr[25:0], 2'b00}
                                      : {{38{in_instr[25]}}, in_instr[25:0]};
        end else if (in_instr[31:25] == 7'b1011010) begin
            dec_fmt = FMT_CB;
            dec_imm = (SHIFT_BR != 0) ? {{43{in_instr[23]}}, in_instr[23:5], 2'b00}
                                      : {{45{in_instr[23]}}, in_instr[23:5]};
        end else if (in_instr[31:21] == 11'b11111000010 || in_instr[31:21] == 11'b11111000000) begin
            dec_fmt = FMT_D;
            dec_imm = {{55{in_instr[20]}}, in_instr[20:12]};
        end else if (in_instr[31:22] == 10'b1001000100 || in_instr[31:22] == 10'b1101000100) begin
            dec_fmt = FMT_I;
            dec_imm = {52'd0, in_instr[21:10]};
`ifdef IMM_GEN_IW_EN
        end else if (in_instr[31:23] == 9'b110100101) begin
            dec_fmt = FMT_IW;
            dec_imm = {48'd0, in_instr[20:5]} << {in_instr[22:21], 4'b0000};
`endif
        end else begin
            dec_err = 1'b1;
        end
    end

    assign out_valid = (count_q != '0);
    assign in_ready  = (count_q != CNT_W'(DEPTH));
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;
    assign count     = count_q;

    // Pointers wrap for free because DEPTH is a power of two.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
            case ({push, pop})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n && !flush && push) begin
            imm_mem_q[wr_ptr_q] <= dec_imm[DATA_W-1:0];
            fmt_mem_q[wr_ptr_q] <= dec_fmt;
            err_mem_q[wr_ptr_q] <= dec_err;
        end
    end

    assign out_imm = out_valid ? imm_mem_q[rd_ptr_q] : '0;
    assign out_fmt = out_valid ? fmt_mem_q[rd_ptr_q] : '0;
    assign out_err = out_valid ? err_mem_q[rd_ptr_q] : 1'b0;

endmodule
